// File: rtl/bch_frame_loader.sv
// BCH decoder input stage: requests 64-bit words, unpacks them into 8-symbol
// beats (hard bits or soft LLRs) and strips the single padding symbol per frame.
module bch_frame_loader #(
  parameter int DEPTH = 2,
  parameter int LLRW  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        mode,
  input  logic [1:0]  code,
  input  logic [63:0] idata,
  output logic        ready,
  output logic        busy,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [7:0]  o_hard,
  output logic [63:0] o_llr,
  output logic [3:0]  o_cnt,
  output logic [6:0]  o_idx,
  output logic        o_last
);

  localparam int SYMS = 64 / LLRW;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t         state;
  logic           mode_q;
  logic [7:0]     num_words, num_beats;
  logic [7:0]     req_cnt, cap_cnt, beat_cnt;
  logic [2:0]     sub;
  logic           cap_pend;
  logic [63:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  occ;

  logic           push, pop, load, head_avail, last_beat, ready_next;
  logic [63:0]    head, head_sh;
  logic [7:0]     beat_hard;
  logic [63:0]    beat_llr;

  // Frame sizes in words; the soft count is eight times the hard count and
  // also equals the beat count of either mode.
  function automatic logic [7:0] hard_words(input logic [1:0] c);
    case (c)
      2'd1:    return 8'd1;
      2'd2:    return 8'd4;
      default: return 8'd16;
    endcase
  endfunction

  // A requested word lands one cycle after ready; an empty FIFO forwards it
  // straight to the output stage so soft mode streams with only two entries.
  assign push       = cap_pend;
  assign head_avail = (occ != '0) || push;
  assign head       = (occ != '0) ? mem[rd_ptr] : idata;
  assign head_sh    = head << {sub, 3'b000};
  assign last_beat  = (beat_cnt == num_beats - 8'd1);
  assign load       = head_avail && (!o_valid || o_ready) && (state != IDLE);
  assign pop        = load && (mode_q || sub == 3'd7);

  assign ready_next = (state == LOAD) && (req_cnt < num_words) &&
                      ((int'(occ) + int'(push) - int'(pop) + int'(ready)) < DEPTH);

  always_comb begin
    beat_hard = '0;
    beat_llr  = '0;
    if (mode_q) begin
      beat_llr = head;
      for (int s = 0; s < SYMS; s++) beat_hard[SYMS-1-s] = head[63-LLRW*s];
    end else begin
      beat_hard = head_sh[63:56];
    end
    if (last_beat) begin
      beat_hard[0]        = 1'b0;
      beat_llr[LLRW-1:0] = '0;
    end
  end

  // NOTE: storage array has no reset; the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= idata;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      num_words <= '0;
      num_beats <= '0;
      req_cnt   <= '0;
      cap_cnt   <= '0;
      beat_cnt  <= '0;
      sub       <= '0;
      cap_pend  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      o_valid   <= 1'b0;
      o_hard    <= '0;
      o_llr     <= '0;
      o_cnt     <= '0;
      o_idx     <= '0;
      o_last    <= 1'b0;
    end else begin
      cap_pend <= ready;
      ready    <= ready_next;
      if (ready_next) req_cnt <= req_cnt + 8'd1;

      if (push) begin
        wr_ptr  <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
        cap_cnt <= cap_cnt + 8'd1;
      end
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      occ <= CW'(int'(occ) + int'(push) - int'(pop));

      case (state)
        IDLE: begin
          if (set && code != 2'd0) begin
            state     <= LOAD;
            mode_q    <= mode;
            num_words <= mode ? (hard_words(code) << 3) : hard_words(code);
            num_beats <= hard_words(code) << 3;
            req_cnt   <= '0;
            cap_cnt   <= '0;
            beat_cnt  <= '0;
            sub       <= '0;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (push && cap_cnt == num_words - 8'd1) state <= DRAIN;
        end
        DRAIN: begin
          if (o_valid && o_ready && o_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        o_valid  <= 1'b1;
        o_hard   <= beat_hard;
        o_llr    <= beat_llr;
        o_cnt    <= last_beat ? 4'd7 : 4'd8;
        o_idx    <= beat_cnt[6:0];
        o_last   <= last_beat;
        beat_cnt <= beat_cnt + 8'd1;
        sub      <= mode_q ? 3'd0 : sub + 3'd1;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bch_frame_loader.md
Name: bch_frame_loader

Overview:
- Input stage of the BCH decoder. Sits between the external word interface (set/mode/code/idata/ready) and the 8-symbol-per-cycle syndrome/LLR pipeline.
- On set, latches mode and code, then requests 64-bit words with ready.
- Unpacks each word into beats of 8 symbols and strips the single padding position of each frame.
- Emits a valid/ready stream with a last-beat marker.

Parameters:
- DEPTH, 2, word buffer entries. Must be 2 or more; 2 gives full soft-mode throughput.
- LLRW, 8, bits per soft symbol. Fixed by the 64-bit word holding 8 symbols.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- set  in  1  one-cycle frame start strobe
- mode  in  1  0 = hard (1 bit per symbol), 1 = soft (8-bit signed LLR per symbol)
- code  in  2  1: n=63, 2: n=255, 3: n=1023; 0 is invalid
- idata  in  64  input word
- ready  out  1  word request to the source
- busy  out  1  high from set acceptance until the last beat is accepted
- o_valid  out  1  beat valid
- o_ready  in  1  downstream accept
- o_hard  out  8  hard decisions; bit 7 = lowest symbol index in the beat
- o_llr  out  64  8 LLRs, [63:56] = lowest index; all 0 in hard mode
- o_cnt  out  4  valid symbols in the beat (8, or 7 on the last beat)
- o_idx  out  7  beat index within the frame, 0..B-1
- o_last  out  1  final beat of the frame

Behaviour:
- Reset: every output is 0, the FIFO is emptied, the FSM goes to IDLE. Reset aborts an in-flight frame; a word arriving the cycle after reset is discarded.
- Word counts:
  - Hard mode: W = 1, 4, 16 and B = 8W, for code 1/2/3.
  - Soft mode: W = B = 8, 32, 128.
  - n = 8B - 1 in every case, so the last beat always carries 7 symbols.
- Source timing: ready high during cycle k means idata is valid and is captured at the clock edge ending cycle k+1. There is no separate valid; the block tracks in-flight requests itself.
- ready is registered and is high only when all of the following hold:
  - state is LOAD;
  - words requested < W;
  - FIFO occupancy + in-flight requests < DEPTH, counting a pop in the same cycle.
- The FIFO never overflows. Exactly W words are requested per frame.
- FSM:
  - IDLE: on set with code != 0, latch mode/code, clear counters, set busy=1, go to LOAD. set with code == 0 is ignored.
  - LOAD: request and unpack words. When all W words are captured, go to DRAIN.
  - DRAIN: emit the remaining beats. When the beat with o_last is accepted (o_valid & o_ready), go to IDLE; busy drops in the same edge.
  - set in LOAD or DRAIN is ignored; latched mode/code do not change mid-frame.
- Unpacking:
  - Hard mode: each word yields 8 beats, MSB first. Beat j takes o_hard = idata[63-8j : 56-8j].
  - Soft mode: each word yields 1 beat. Symbol s is idata[63-8s : 56-8s], two's complement; o_hard bit = LLR sign bit (negative gives 1).
- Padding: the last beat drops symbol position 7 (hard: bit 0 of the last word; soft: byte [7:0] of the last word). In that beat o_cnt = 7, o_hard[0] = 0 and o_llr[7:0] = 0.
- Output stage:
  - Registered. While o_valid & !o_ready, all o_* stay stable.
  - The first beat has o_valid high on the cycle after the first word is captured.
  - o_idx increments by 1 per accepted beat and wraps to 0 with the next frame.
- Throughput:
  - Soft mode with o_ready held high: ready stays high for W consecutive cycles and o_valid is continuous for B cycles.
  - Hard mode: one word per 8 beats, so ready pulses about every 8 cycles.
- Back-to-back frames: a set on the same cycle as the last-beat accept is ignored. A set one cycle later starts a new frame.

Test Plan:
- Reset, then set code=1 mode=0 with idata=64'hFFFF_0000_A5A5_0001 and o_ready=1. Required: ready high for exactly 1 cycle; 8 beats with o_hard = FF,FF,00,00,A5,A5,00,00; beat 7 has o_cnt=7, o_last=1, o_idx=7; busy=0 afterwards.
- code=2, mode=1, 32 words with byte s = s-4 (signed), o_ready=1. Required: 32 contiguous beats; o_hard=8'hF0 each beat (bytes 0..3 negative); o_cnt=7 and o_llr[7:0]=0 on beat 31 only.
- Same as the previous scenario with o_ready toggling 1/0 every cycle. Required: identical beat sequence, o_* stable while stalled, exactly 32 words requested, no word lost.
- code=3, mode=0, 16 words. Required: 128 beats; o_idx runs 0..127; o_last only at 127; a set pulse applied at beat 50 changes nothing.
- rst asserted at beat 10 of a code=3 soft frame, released, then a code=1 hard frame. Required: outputs are 0 on the cycle after reset; the new frame starts cleanly with o_idx=0.
- set with code=0. Required: busy and ready stay 0 and no beats are emitted.
